// File: rtl/reg_file_3r1w_pkg.sv
// Constants shared by the register file and the register-status logic.
// Also holds the bounds check used by every read port.
package reg_file_3r1w_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int REG_INDEX     = 5;
  localparam int REG_FILE_SIZE = 32;
  localparam int FU_INDEX      = 3;

  // Functional-unit tag meaning "value already in the register file".
  localparam logic [FU_INDEX-1:0] READY = '0;

  function automatic logic addr_in_range(input logic [31:0] idx, input int size);
    return idx < 32'(size);
  endfunction

endpackage

// File: rtl/reg_file_3r1w.sv
// Architectural register file: three combinational read ports and one write port
// that commits on the falling clock edge, with an asynchronous clear.
module reg_file_3r1w #(
  parameter int WORD_SIZE     = reg_file_3r1w_pkg::WORD_SIZE,
  parameter int REG_INDEX     = reg_file_3r1w_pkg::REG_INDEX,
  parameter int REG_FILE_SIZE = reg_file_3r1w_pkg::REG_FILE_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_INDEX-1:0] get_num1,
  input  logic [REG_INDEX-1:0] get_num2,
  input  logic [REG_INDEX-1:0] get_num3,
  output logic [WORD_SIZE-1:0] value1,
  output logic [WORD_SIZE-1:0] value2,
  output logic [WORD_SIZE-1:0] value3,
  input  logic [REG_INDEX-1:0] write_reg_src,
  input  logic [WORD_SIZE-1:0] write_reg_data,
  input  logic                 write_reg_enable
);
  import reg_file_3r1w_pkg::*;

  logic [WORD_SIZE-1:0] regs_flat [REG_FILE_SIZE];

  // Each word decodes its own write select, so an unknown write address
  // matches no entry and the array is left intact.
  genvar gi;
  generate
    for (gi = 0; gi < REG_FILE_SIZE; gi++) begin : g_word
      logic [WORD_SIZE-1:0] word_reg;

      always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
          word_reg <= '0;
        end else if (write_reg_enable && (write_reg_src == REG_INDEX'(gi))) begin
          word_reg <= write_reg_data;
        end
      end

      assign regs_flat[gi] = word_reg;
    end
  endgenerate

  function automatic logic [WORD_SIZE-1:0] read_word(input logic [REG_INDEX-1:0] addr);
    read_word = '0;
    if (addr_in_range(32'(addr), REG_FILE_SIZE)) begin
      read_word = regs_flat[addr];
    end
  endfunction

  assign value1 = read_word(get_num1);
  assign value2 = read_word(get_num2);
  assign value3 = read_word(get_num3);

endmodule

// File: tb/tb_reg_file_3r1w.sv
// Self-checking bench for reg_file_3r1w: directed scenarios plus randomized
// traffic compared against a plain array model of the register contents.
module tb_reg_file_3r1w;
  import reg_file_3r1w_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [REG_INDEX-1:0] get_num1 = '0;
  logic [REG_INDEX-1:0] get_num2 = '0;
  logic [REG_INDEX-1:0] get_num3 = '0;
  logic [WORD_SIZE-1:0] value1;
  logic [WORD_SIZE-1:0] value2;
  logic [WORD_SIZE-1:0] value3;
  logic [REG_INDEX-1:0] write_reg_src = '0;
  logic [WORD_SIZE-1:0] write_reg_data = '0;
  logic                 write_reg_enable = 1'b0;

  logic [WORD_SIZE-1:0] model [REG_FILE_SIZE];
  int checks = 0;
  int errors = 0;

  reg_file_3r1w dut (
    .clk              (clk),
    .reset            (reset),
    .get_num1         (get_num1),
    .get_num2         (get_num2),
    .get_num3         (get_num3),
    .value1           (value1),
    .value2           (value2),
    .value3           (value3),
    .write_reg_src    (write_reg_src),
    .write_reg_data   (write_reg_data),
    .write_reg_enable (write_reg_enable)
  );

  // posedge at 5, 15, ...; negedge (write edge) at 10, 20, ...
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < REG_FILE_SIZE; i++) model[i] = '0;
  endtask

  // Drive one write after a posedge, let it cross the following negedge.
  task automatic write_cycle(input int idx, input logic [WORD_SIZE-1:0] data, input logic en);
    @(posedge clk); #1;
    write_reg_src    = REG_INDEX'(idx);
    write_reg_data   = data;
    write_reg_enable = en;
    @(negedge clk); #1;
    if (en && !reset) begin
      model[idx] = data;
      $display("%0t: reg[%0d] = %h", $time, idx, data);
    end
    write_reg_enable = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1 reset = 1'b0;
    model_clear();
    for (int i = 0; i < REG_FILE_SIZE; i++) begin
      get_num1 = REG_INDEX'(i);
      get_num2 = REG_INDEX'((i + 1) % REG_FILE_SIZE);
      get_num3 = REG_INDEX'((i + 2) % REG_FILE_SIZE);
      #0.1;
      checks++;
      if (value1 !== '0 || value2 !== '0 || value3 !== '0) begin
        errors++;
        $display("FAIL reset_clear idx=%0d got %h/%h/%h want 0", i, value1, value2, value3);
      end
    end
    $display("%0t: reset pulse, all %0d registers read 0 checked", $time, REG_FILE_SIZE);
  endtask

  task automatic test_write_edge();
    get_num1 = 5;
    @(posedge clk); #1;
    write_reg_src = 5; write_reg_data = 32'hDEADBEEF; write_reg_enable = 1'b1;
    #1;
    checks++;
    if (value1 !== 32'h0) begin
      errors++;
      $display("FAIL write_before_edge got %h want %h", value1, 32'h0);
    end
    @(negedge clk); #1;
    write_reg_enable = 1'b0;
    model[5] = 32'hDEADBEEF;
    $display("%0t: reg[5] = %h", $time, 32'hDEADBEEF);
    checks++;
    if (value1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_after_edge got %h want %h", value1, 32'hDEADBEEF);
    end
  endtask

  task automatic test_enable_low();
    get_num1 = 5;
    write_cycle(5, 32'h12345678, 1'b0);
    checks++;
    if (value1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL enable_low got %h want %h", value1, 32'hDEADBEEF);
    end
    // Write held across a posedge must not land until the next negedge.
    @(negedge clk); #1;
    write_reg_src = 5; write_reg_data = 32'hCAFEF00D; write_reg_enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (value1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL posedge_no_write got %h want %h", value1, 32'hDEADBEEF);
    end
    @(negedge clk); #1;
    write_reg_enable = 1'b0;
    model[5] = 32'hCAFEF00D;
    $display("%0t: reg[5] = %h", $time, 32'hCAFEF00D);
    checks++;
    if (value1 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL negedge_write got %h want %h", value1, 32'hCAFEF00D);
    end
  endtask

  task automatic test_multi_read();
    write_cycle(3, 32'h11, 1'b1);
    write_cycle(7, 32'h22, 1'b1);
    get_num1 = 3; get_num2 = 7; get_num3 = 3;
    #1;
    checks++;
    if (value1 !== 32'h11 || value2 !== 32'h22 || value3 !== 32'h11) begin
      errors++;
      $display("FAIL multi_read got %h/%h/%h want 11/22/11", value1, value2, value3);
    end
  endtask

  task automatic test_boundary();
    write_cycle(31, 32'hFFFFFFFF, 1'b1);
    write_cycle(0, 32'h1, 1'b1);
    get_num1 = 31; get_num2 = 0; get_num3 = 30;
    #1;
    checks++;
    if (value1 !== 32'hFFFFFFFF || value2 !== 32'h1 || value3 !== 32'h0) begin
      errors++;
      $display("FAIL boundary_31_0_30 got %h/%h/%h want ffffffff/1/0", value1, value2, value3);
    end
    get_num3 = 1;
    #1;
    checks++;
    if (value3 !== 32'h0) begin
      errors++;
      $display("FAIL boundary_reg1 got %h want 0", value3);
    end
    reset = 1'b1;
    #1;
    model_clear();
    checks++;
    if (value1 !== '0 || value2 !== '0) begin
      errors++;
      $display("FAIL boundary_async_reset got %h/%h want 0/0", value1, value2);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_vs_write();
    get_num1 = 9;
    @(posedge clk); #1;
    write_reg_src = 9; write_reg_data = 32'hAA; write_reg_enable = 1'b1;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (value1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_blocks_write got %h want 0", value1);
    end
    reset = 1'b0;
    @(negedge clk); #1;
    write_reg_enable = 1'b0;
    model[9] = 32'hAA;
    $display("%0t: reg[9] = %h", $time, 32'hAA);
    checks++;
    if (value1 !== 32'hAA) begin
      errors++;
      $display("FAIL write_after_reset got %h want %h", value1, 32'hAA);
    end
  endtask

  task automatic test_random();
    int addr, r1, r2, r3;
    logic [WORD_SIZE-1:0] data;
    logic en;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      addr = $urandom_range(0, REG_FILE_SIZE - 1);
      data = $urandom;
      en   = 1'($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 2) == 0) ? addr : $urandom_range(0, REG_FILE_SIZE - 1);
      r2 = $urandom_range(0, REG_FILE_SIZE - 1);
      r3 = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, REG_FILE_SIZE - 1);
      get_num1 = REG_INDEX'(r1); get_num2 = REG_INDEX'(r2); get_num3 = REG_INDEX'(r3);
      write_reg_src = REG_INDEX'(addr); write_reg_data = data; write_reg_enable = en;
      #1;
      checks++;
      if (value1 !== model[r1] || value2 !== model[r2] || value3 !== model[r3]) begin
        errors++;
        $display("FAIL rand_pre_edge n=%0d got %h/%h/%h want %h/%h/%h",
                 n, value1, value2, value3, model[r1], model[r2], model[r3]);
      end
      @(negedge clk); #1;
      write_reg_enable = 1'b0;
      if (en) begin
        model[addr] = data;
        $display("%0t: reg[%0d] = %h", $time, addr, data);
      end
      checks++;
      if (value1 !== model[r1] || value2 !== model[r2] || value3 !== model[r3]) begin
        errors++;
        $display("FAIL rand_post_edge n=%0d got %h/%h/%h want %h/%h/%h",
                 n, value1, value2, value3, model[r1], model[r2], model[r3]);
      end
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b1;
        #1;
        model_clear();
        reset = 1'b0;
        checks++;
        if (value1 !== '0 || value2 !== '0 || value3 !== '0) begin
          errors++;
          $display("FAIL rand_reset n=%0d got %h/%h/%h want 0", n, value1, value2, value3);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write_edge();
    test_enable_low();
    test_multi_read();
    test_boundary();
    test_reset_vs_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_3r1w.md
Name: reg_file_3r1w

Overview:
- General-purpose architectural register file for the CPU: three combinational read ports and one synchronous write port.
- Sits inside the register-status block, which pairs each register value with a functional-unit tag.
- Operand fetch reads up to three source registers per cycle; the common-data-bus writeback drives the single write port.

Parameters:
- WORD_SIZE, 32, data width of each register in bits.
- REG_INDEX, 5, width of register address fields.
- REG_FILE_SIZE, 32, number of registers; must be <= 2**REG_INDEX.

Ports:
- clk  input  1  clock; writes occur on the falling edge.
- reset  input  1  asynchronous, active-high; clears all registers.
- get_num1  input  REG_INDEX  read address, port 1.
- get_num2  input  REG_INDEX  read address, port 2.
- get_num3  input  REG_INDEX  read address, port 3.
- value1  output  WORD_SIZE  contents of register get_num1.
- value2  output  WORD_SIZE  contents of register get_num2.
- value3  output  WORD_SIZE  contents of register get_num3.
- write_reg_src  input  REG_INDEX  write address.
- write_reg_data  input  WORD_SIZE  write data.
- write_reg_enable  input  1  write strobe, active-high.

Behaviour:
- Storage: REG_FILE_SIZE words of WORD_SIZE bits each.
- Reset:
  - When reset rises, all registers are cleared to 0 immediately, independent of clk.
  - While reset is high, all registers hold 0 and writes are ignored.
  - value1..3 read 0 during and after reset until written.
- Write:
  - On each negedge clk with reset low and write_reg_enable=1, regs[write_reg_src] <= write_reg_data.
  - With enable=0, no register changes.
  - The falling edge matches the register-status table, so producers set up on posedge and the write lands mid-cycle.
- Read:
  - Purely combinational: valueN = regs[get_numN]. Zero latency, no clock involvement.
  - All three ports are independent; any two or all three may address the same register.
- Read-during-write:
  - No internal bypass. A read of the register being written returns the old value until the write edge, then the new value in the same delta cycle after the edge.
- Register 0 is an ordinary writable register; there is no hardwired zero.
- Out-of-range addresses (index >= REG_FILE_SIZE):
  - Writes are ignored.
  - Reads return 0.
- X-handling: an X or Z write address with enable=1 leaves the contents unchanged; implementations must not corrupt the whole array.
- Reset asserted in the same instant as a write edge: reset wins and all registers are 0.
- Debug: each accepted write emits a simulation-only display line "time: reg[idx] = data". It has no functional effect.

Decomposition:
- Shared package holds WORD_SIZE, REG_INDEX, REG_FILE_SIZE, FU_INDEX and READY, the constants common to the register file and register-status logic.
- The block is one module: flat array plus three read muxes. No sub-module is required.
- An optional helper function may perform the bounds-checked read so the three ports share one implementation.

Test Plan:
- Assert reset for 1 ns mid-cycle, then read all 32 indices on the three ports -> every value is 0, with no clock edge required.
- Write reg 5 = 0xDEADBEEF with enable=1 across a negedge; get_num1=5 -> value1 is old value 0 before the edge and 0xDEADBEEF right after.
- Present the same write with write_reg_enable=0 -> reg 5 is unchanged. Also hold the write across a posedge only -> no update until the following negedge.
- Write reg 3=0x11, then reg 7=0x22; set get_num1=3, get_num2=7, get_num3=3 -> value1=0x11, value2=0x22, value3=0x11 simultaneously.
- Write reg 31=0xFFFFFFFF and reg 0=0x1 -> both readable, no interference with neighbours 30 and 1 (which read 0). Then assert reset -> both read 0 immediately.
- Hold write_reg_enable=1 while asserting reset across a negedge -> target register stays 0. Deassert reset -> the next negedge write takes effect.
